// File: rtl/bypass_mux_reg.sv
// N-source operand bypass selector with a registered output stage for the ID/EX boundary.
// Optional saturating bypass/hazard statistics counters are enabled by defining BYPASS_STATS_EN.
module bypass_mux_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int TAGW  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [TAGW-1:0]       src_tag,
  input  logic [WIDTH-1:0]      rf_data,
  input  logic [NSRC-1:0]       byp_valid,
  input  logic [NSRC-1:0]       byp_ready,
  input  logic [NSRC*TAGW-1:0]  byp_tag,
  input  logic [NSRC*WIDTH-1:0] byp_data,
  output logic                  hazard,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [NSRC:0]         out_sel
`ifdef BYPASS_STATS_EN
  ,
  output logic [31:0]           stat_bypass,
  output logic [31:0]           stat_hazard
`endif
);

  logic [NSRC-1:0]  match;
  logic [NSRC:0]    sel_oh;
  logic [WIDTH-1:0] sel_data;
  logic             win_found;
  logic             win_ready;

  // Register 0 is hard-wired, so a zero tag never forwards.
  for (genvar g = 0; g < NSRC; g++) begin : g_match
    assign match[g] = byp_valid[g] && (byp_tag[g*TAGW +: TAGW] == src_tag) && (src_tag != '0);
  end

  // Walk from oldest to youngest so the lowest matching index is the last writer and wins,
  // including when that producer is not ready (it still shadows older ready ones).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    sel_oh    = '0;
    sel_data  = rf_data;
    win_found = 1'b0;
    win_ready = 1'b1;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_data  = byp_data[i*WIDTH +: WIDTH];
        win_found = 1'b1;
        win_ready = byp_ready[i];
      end
    end
    if (!win_found) sel_oh[NSRC] = 1'b1;
  end

  assign hazard = in_valid && win_found && !win_ready;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values together.
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (stall) begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end else if (hazard || !in_valid) begin
      // A hazard inserts a bubble; an idle request also captures zeros.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= sel_oh;
    end
  end

`ifdef BYPASS_STATS_EN
  logic bypass_evt;
  logic hazard_evt;

  assign bypass_evt = !flush && !stall && !hazard && in_valid && !sel_oh[NSRC];
  assign hazard_evt = hazard && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bypass <= '0;
      stat_hazard <= '0;
    end else begin
      if (bypass_evt && (stat_bypass != 32'hFFFF_FFFF)) stat_bypass <= stat_bypass + 32'd1;
      if (hazard_evt && (stat_hazard != 32'hFFFF_FFFF)) stat_hazard <= stat_hazard + 32'd1;
    end
  end
`endif

endmodule

// File: doc/bypass_mux_reg.md
Name: bypass_mux_reg

Overview:
- Parametrised N-source operand bypass (forwarding) selector with a registered output stage.
- Sits at the ID/EX boundary of the dynamic pipeline and replaces the ad-hoc 2:1 operand muxes.
- Picks the youngest in-flight producer whose destination tag matches the operand tag; otherwise passes register-file data.
- Flags a load-use style hazard when the matching producer's result is not yet available, and holds or flushes under pipeline control.

Parameters:
- WIDTH, 32, data width in bits
- NSRC, 4, number of bypass sources; index 0 is the youngest stage (highest priority)
- TAGW, 5, register tag width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold the output register
- flush  input  1  invalidate the output register
- in_valid  input  1  operand request valid this cycle
- src_tag  input  TAGW  operand register tag
- rf_data  input  WIDTH  register-file read data
- byp_valid  input  NSRC  source i holds an in-flight write to byp_tag[i]
- byp_ready  input  NSRC  source i result is available in byp_data[i]
- byp_tag  input  NSRC*TAGW  packed tags; source i at [i*TAGW +: TAGW]
- byp_data  input  NSRC*WIDTH  packed data; source i at [i*WIDTH +: WIDTH]
- hazard  output  1  combinational; matched producer not ready, so upstream must stall
- out_valid  output  1  registered operand valid
- out_data  output  WIDTH  registered operand value
- out_sel  output  NSRC+1  registered one-hot select; bit i = source i, bit NSRC = register file

Behaviour:
- Match: match[i] = byp_valid[i] && byp_tag[i]==src_tag && src_tag!=0. Tag 0 is never bypassed and always reads rf_data.
- Priority: the lowest matching index wins. Lower-indexed matches fully shadow higher ones, regardless of ready.
- No match: select the register file; sel = bit NSRC.
- hazard = in_valid && winner exists && !byp_ready[winner]. It is purely combinational, zero latency, and independent of stall/flush/rst.
- Register update priority on each rising clk edge:
  1. rst: out_valid=0, out_data=0, out_sel=0. Reset in the middle of a stall or hazard clears everything in the same edge.
  2. flush: out_valid=0, out_data=0, out_sel=0. Flush overrides stall.
  3. stall: all outputs hold their previous values.
  4. Otherwise, when hazard=1: out_valid=0, out_data=0, out_sel=0. This inserts a bubble; the selected data is not captured.
  5. Otherwise: out_valid=in_valid, out_data=selected value, out_sel=one-hot select. When in_valid=0, out_data and out_sel are captured as 0.
- Latency: 1 cycle from inputs to out_*.
- Width rules: exact WIDTH pass-through with no extension or truncation. NSRC=1 must elaborate.
- Matching ignores byp_valid=0 entries even when their tags match.

Optional Feature:
- Macro: BYPASS_STATS_EN.
- When defined, adds two outputs: stat_bypass (32 bits) and stat_hazard (32 bits).
  - stat_bypass increments on each non-stalled, non-flushed capture with in_valid=1 whose select is not the register file.
  - stat_hazard increments on every cycle with hazard=1 and stall=0.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- When undefined: no stat ports exist and no counter logic is generated. Core behaviour is identical in both builds.

Test Plan:
- RF path: rst then release; src_tag=5, rf_data=0x1111_1111, byp_valid=0 -> next cycle out_valid=1, out_data=0x11111111, out_sel=1<<NSRC.
- Priority: src_tag=7; sources 1 and 3 valid, ready, tag 7, data 0xA1 and 0xA3 -> out_data=0xA1, out_sel=0b00010.
- Hazard: source 0 valid, tag 7, not ready; source 2 ready, tag 7 -> hazard=1 in the same cycle, next cycle out_valid=0. Setting byp_ready[0]=1 -> hazard=0, and next cycle out_data=byp_data[0].
- R0 guard: src_tag=0, source 0 valid, tag 0, data 0xDEAD -> out_data=rf_data and hazard=0.
- Stall/flush: capture 0x55, then stall=1 for 3 cycles while inputs change -> output holds 0x55. Then stall=1 with flush=1 -> out_valid=0, out_data=0.
- Reset mid-op: with out_valid=1 and stall=1, assert rst for one cycle -> all outputs 0 next edge. With BYPASS_STATS_EN defined, the counters also read 0.
